// File: rtl/jelly_vin_capture_ctl.sv
// jelly_vin_capture_ctl: frame-aligned capture sequencer between a non-stallable video stream and a back-pressured AXI4-Stream sink
module jelly_vin_capture_ctl #(
  parameter int WIDTH           = 24,
  parameter int X_WIDTH         = 12,
  parameter int Y_WIDTH         = 12,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       reset,
  input  logic                       clk,
  input  logic                       ctl_start,
  input  logic                       ctl_stop,
  input  logic                       ctl_continuous,
  input  logic [FRAME_CNT_WIDTH-1:0] ctl_frame_num,
  input  logic                       s_axi4s_tuser,
  input  logic                       s_axi4s_tlast,
  input  logic [WIDTH-1:0]           s_axi4s_tdata,
  input  logic                       s_axi4s_tvalid,
  output logic                       m_axi4s_tuser,
  output logic                       m_axi4s_tlast,
  output logic [WIDTH-1:0]           m_axi4s_tdata,
  output logic                       m_axi4s_tvalid,
  input  logic                       m_axi4s_tready,
  output logic                       stat_busy,
  output logic [FRAME_CNT_WIDTH-1:0] stat_frame_count,
  output logic [X_WIDTH-1:0]         stat_width,
  output logic [Y_WIDTH-1:0]         stat_height,
  output logic                       stat_overflow
);
  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DROP} state_t;
  state_t                     state_q, state_d;
  logic                       cont_q, cont_d;
  logic                       stop_req_q, stop_req_d;
  logic                       ovf_q, ovf_d;
  logic [FRAME_CNT_WIDTH-1:0] num_q, num_d;
  logic [FRAME_CNT_WIDTH-1:0] fc_q, fc_d;
  logic [X_WIDTH-1:0]         x_q, x_d, x_base, x_inc, wid_q, wid_d;
  logic [Y_WIDTH-1:0]         y_q, y_d, y_base, y_inc, hgt_q, hgt_d;
  logic                       m_valid_q, m_valid_d;
  logic                       sof, done, fwd, lost, take;
  assign sof  = s_axi4s_tvalid && s_axi4s_tuser;
  assign done = stop_req_q || ctl_stop || (!cont_q && fc_q == num_q);
  always_comb begin
    state_d    = state_q;
    cont_d     = cont_q;
    num_d      = num_q;
    fc_d       = fc_q;
    stop_req_d = stop_req_q;
    ovf_d      = ovf_q;
    fwd        = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctl_start && !ctl_stop) begin
          state_d    = WAIT_SOF;
          cont_d     = ctl_continuous;
          num_d      = (ctl_frame_num == '0) ? FRAME_CNT_WIDTH'(1) : ctl_frame_num;
          fc_d       = '0;
          ovf_d      = 1'b0;
          stop_req_d = 1'b0;
        end
      end
      WAIT_SOF: begin
        if (ctl_stop) state_d = IDLE;
        else if (sof) begin
          fwd     = 1'b1;
          state_d = CAPTURE;
        end
      end
      default: begin
        if (ctl_stop) stop_req_d = 1'b1;
        if (sof) begin
          state_d = done ? IDLE : CAPTURE;
          fwd     = !done;
        end else fwd = s_axi4s_tvalid && state_q == CAPTURE;
      end
    endcase
    if (fwd && s_axi4s_tuser) fc_d = fc_q + FRAME_CNT_WIDTH'(1);
    if (lost) begin
      ovf_d   = 1'b1;
      state_d = DROP;
    end
  end
  // A beat that arrives while the held beat is still stalled has nowhere to go.
  assign lost      = fwd && m_valid_q && !m_axi4s_tready;
  assign take      = fwd && !lost;
  assign m_valid_d = take || (m_valid_q && !m_axi4s_tready);
  always_comb begin
    x_base = s_axi4s_tuser ? '0 : x_q;
    x_inc  = &x_base ? x_base : x_base + X_WIDTH'(1);
    y_base = s_axi4s_tuser ? '0 : y_q;
    y_inc  = &y_base ? y_base : y_base + Y_WIDTH'(1);
    x_d    = fwd ? (s_axi4s_tlast ? '0 : x_inc) : x_q;
    y_d    = fwd ? (s_axi4s_tlast ? y_inc : y_base) : y_q;
    wid_d  = (fwd && s_axi4s_tlast) ? x_inc : wid_q;
    hgt_d  = (sof && state_q == CAPTURE) ? y_q : hgt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cont_q     <= 1'b0;
      num_q      <= '0;
      fc_q       <= '0;
      stop_req_q <= 1'b0;
      ovf_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      wid_q      <= '0;
      hgt_q      <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cont_q     <= cont_d;
      num_q      <= num_d;
      fc_q       <= fc_d;
      stop_req_q <= stop_req_d;
      ovf_q      <= ovf_d;
      x_q        <= x_d;
      y_q        <= y_d;
      wid_q      <= wid_d;
      hgt_q      <= hgt_d;
      m_valid_q  <= m_valid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (take) begin
      m_axi4s_tuser <= s_axi4s_tuser;
      m_axi4s_tlast <= s_axi4s_tlast;
      m_axi4s_tdata <= s_axi4s_tdata;
    end
  end
  assign m_axi4s_tvalid   = m_valid_q;
  assign stat_busy        = state_q != IDLE;
  assign stat_frame_count = fc_q;
  assign stat_width       = wid_q;
  assign stat_height      = hgt_q;
  assign stat_overflow    = ovf_q;
endmodule

// File: tb/tb_jelly_vin_capture_ctl.sv
// tb_jelly_vin_capture_ctl: scoreboard bench for the capture sequencer
module tb_jelly_vin_capture_ctl;
  logic        reset = 1'b1, clk = 1'b0;
  logic        ctl_start = 0, ctl_stop = 0, ctl_continuous = 0;
  logic [7:0]  ctl_frame_num = 0;
  logic        s_tuser = 0, s_tlast = 0, s_tvalid = 0;
  logic [23:0] s_tdata = 0;
  logic        m_tuser, m_tlast, m_tvalid, m_tready = 1;
  logic [23:0] m_tdata;
  logic        stat_busy, stat_overflow;
  logic [7:0]  stat_frame_count;
  logic [11:0] stat_width, stat_height;
  logic [25:0] sb[$];
  int          n_tests = 0, n_fail = 0, n_out = 0;
  bit          want_first = 0;
  jelly_vin_capture_ctl dut (
    .reset(reset), .clk(clk),
    .ctl_start(ctl_start), .ctl_stop(ctl_stop), .ctl_continuous(ctl_continuous), .ctl_frame_num(ctl_frame_num),
    .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata), .s_axi4s_tvalid(s_tvalid),
    .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tdata(m_tdata), .m_axi4s_tvalid(m_tvalid),
    .m_axi4s_tready(m_tready),
    .stat_busy(stat_busy), .stat_frame_count(stat_frame_count), .stat_width(stat_width),
    .stat_height(stat_height), .stat_overflow(stat_overflow)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // A handshake seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      if (sb.size() == 0) check("unexpected_beat", {m_tuser, m_tlast, m_tdata}, 64'hdead);
      else begin
        check("beat", {m_tuser, m_tlast, m_tdata}, sb.pop_front());
        n_out++;
        if (want_first) begin
          check("first_tuser", m_tuser, 1);
          want_first = 0;
        end
      end
    end
  end
  task automatic beat(input bit u, input bit l, input logic [23:0] d, input bit exp, input bit rdy, input bit stp);
    @(posedge clk); #1;
    s_tvalid = 1; s_tuser = u; s_tlast = l; s_tdata = d;
    m_tready = rdy; ctl_stop = stp; ctl_start = 0;
    if (exp) sb.push_back({u, l, d});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s_tvalid = 0; s_tuser = 0; s_tlast = 0;
      ctl_start = 0; ctl_stop = 0; m_tready = 1;
    end
  endtask
  task automatic ctl(input bit st, input bit sp, input bit cont, input logic [7:0] num);
    @(posedge clk); #1;
    s_tvalid = 0; s_tuser = 0; s_tlast = 0; m_tready = 1;
    ctl_start = st; ctl_stop = sp; ctl_continuous = cont; ctl_frame_num = num;
  endtask
  task automatic frame(input int fid, input int w, input int h, input bit exp, input int cut, input int stall, input int stop);
    int i;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        i = y * w + x;
        beat(i == 0, x == w - 1, {8'(fid), 8'(y), 8'(x)}, exp && i < cut, !(i >= stall && i < stall + 2), i == stop);
      end
  endtask
  initial begin
    idle(3);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_busy", stat_busy, 0);
    check("rst_fc", stat_frame_count, 0);
    check("rst_width", stat_width, 0);
    check("rst_height", stat_height, 0);
    check("rst_ovf", stat_overflow, 0);
    reset = 0;
    // N-frame capture
    ctl(1, 0, 0, 2);
    idle(1);
    frame(1, 4, 3, 1, 99, 99, -1);
    frame(2, 4, 3, 1, 99, 99, -1);
    frame(3, 4, 3, 0, 99, 99, -1);
    idle(3);
    check("t1_beats", n_out, 24);
    check("t1_busy", stat_busy, 0);
    check("t1_width", stat_width, 4);
    check("t1_height", stat_height, 3);
    check("t1_fc", stat_frame_count, 2);
    check("t1_sb_empty", sb.size(), 0);
    // continuous with stop mid-frame
    n_out = 0;
    ctl(1, 0, 1, 0);
    frame(4, 4, 3, 1, 99, 99, -1);
    frame(5, 4, 3, 1, 99, 99, 5);
    beat(1, 0, {8'd6, 8'd0, 8'd0}, 0, 1, 0);
    check("t2_busy_at_sof", stat_busy, 1);
    beat(0, 0, {8'd6, 8'd0, 8'd1}, 0, 1, 0);
    check("t2_busy_after_sof", stat_busy, 0);
    idle(3);
    check("t2_beats", n_out, 24);
    check("t2_fc", stat_frame_count, 2);
    check("t2_sb_empty", sb.size(), 0);
    // start mid-frame, frame_num 0 acts as 1
    ctl(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) beat(0, i % 4 == 3, {8'd7, 8'(i / 4 + 1), 8'(i % 4)}, 0, 1, 0);
    want_first = 1;
    frame(8, 4, 3, 1, 99, 99, -1);
    frame(9, 4, 3, 0, 99, 99, -1);
    idle(3);
    check("t3_first_seen", want_first, 0);
    check("t3_fc", stat_frame_count, 1);
    check("t3_busy", stat_busy, 0);
    check("t3_sb_empty", sb.size(), 0);
    // stall -> overflow -> drop -> resume
    ctl(1, 0, 1, 0);
    frame(10, 4, 3, 1, 99, 99, -1);
    frame(11, 4, 3, 1, 5, 5, -1);
    check("t4_ovf", stat_overflow, 1);
    check("t4_busy_drop", stat_busy, 1);
    frame(12, 4, 2, 1, 99, 99, -1);
    check("t4_ovf_sticky", stat_overflow, 1);
    check("t4_fc", stat_frame_count, 3);
    idle(2);
    ctl(0, 1, 1, 0);
    frame(13, 4, 3, 0, 99, 99, -1);
    idle(3);
    check("t4_busy", stat_busy, 0);
    check("t4_height", stat_height, 2);
    check("t4_sb_empty", sb.size(), 0);
    // start+stop together, stop in WAIT_SOF
    ctl(1, 1, 0, 1);
    idle(1);
    check("t5_busy_both", stat_busy, 0);
    check("t5_ovf_kept", stat_overflow, 1);
    ctl(1, 0, 0, 1);
    idle(1);
    check("t5_busy_start", stat_busy, 1);
    check("t5_ovf_clr", stat_overflow, 0);
    check("t5_fc_clr", stat_frame_count, 0);
    ctl(0, 1, 0, 1);
    idle(1);
    check("t5_busy_stop", stat_busy, 0);
    frame(14, 4, 3, 0, 99, 99, -1);
    idle(2);
    check("t5_busy_end", stat_busy, 0);
    check("t5_sb_empty", sb.size(), 0);
    // reset while a stalled beat is held in CAPTURE
    ctl(1, 0, 1, 0);
    idle(1);
    beat(1, 0, {8'd15, 8'd0, 8'd0}, 0, 0, 0);
    @(posedge clk); #1;
    s_tvalid = 0; reset = 1;
    check("t6_held", m_tvalid, 1);
    check("t6_busy_pre", stat_busy, 1);
    check("t6_width_pre", stat_width, 4);
    @(posedge clk); #1;
    check("t6_tvalid", m_tvalid, 0);
    check("t6_busy", stat_busy, 0);
    check("t6_fc", stat_frame_count, 0);
    check("t6_width", stat_width, 0);
    check("t6_height", stat_height, 0);
    check("t6_ovf", stat_overflow, 0);
    reset = 0;
    idle(3);
    check("final_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
